// File: rtl/cov_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cov_bist_ctrl_if
// Purpose  : Bundle between the BIST engine and its environment. It carries
//            the stimulus/response wires to the block under test and the
//            run-control/status signals.
// Revision : 1.0  initial release
// ============================================================================
interface cov_bist_ctrl_if #(
  parameter int CNT_W = 4
);
  // run control and status
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] test_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             fail_valid;
  logic [2:0]       fail_vec;
  // stimulus to, and response from, the block under test
  logic             a_o;
  logic             b_o;
  logic             c_o;
  logic             z_i;

  // BIST engine side
  modport master (
    input  start, z_i,
    output busy, done, pass, test_cnt, err_cnt, fail_valid, fail_vec,
    output a_o, b_o, c_o
  );

  // Environment side: requests runs, reads results, answers with z
  modport slave (
    output start, z_i,
    input  busy, done, pass, test_cnt, err_cnt, fail_valid, fail_vec,
    input  a_o, b_o, c_o
  );
endinterface
`default_nettype wire

// File: rtl/cov_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cov_bist_ctrl
// Purpose  : Exhaustive BIST engine for z = a & (b | c). Steps {a,b,c} through
//            all 8 combinations, holds each for SETTLE_CYCLES, samples z,
//            compares against the golden function and reports pass/fail,
//            error count and the first failing vector.
// Revision : 1.0  initial release
// ============================================================================
module cov_bist_ctrl #(
  parameter int SETTLE_CYCLES = 1,   // 1..15
  parameter int CNT_W         = 4    // >= 4 so the value 8 fits
) (
  input  logic            clk,
  input  logic            rst_n,
  cov_bist_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [2:0]       vec;          // vector index; doubles as {a,b,c}
  logic [3:0]       settle_cnt;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] test_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             fail_valid;
  logic [2:0]       fail_vec;

  logic             expected;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt_next;

  // Golden model on the vector currently driven, and the saturating error
  // count that a CHECK edge would store.
  assign expected     = vec[2] & (vec[1] | vec[0]);
  assign mismatch     = (bus.z_i != expected);
  assign err_cnt_next = (mismatch && (err_cnt != CNT_MAX)) ? err_cnt + CNT_ONE : err_cnt;

  // Run sequencer: all results are registered so they stay stable in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= 3'b000;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      test_cnt   <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 3'b000;
    end else begin
      case (state)
        // A restart from DONE behaves exactly like a start from IDLE.
        IDLE, DONE: begin
          if (bus.start) begin
            vec        <= 3'b000;
            settle_cnt <= 4'd0;
            test_cnt   <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'b000;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end
        end

        CHECK: begin
          if (test_cnt != CNT_MAX) begin
            test_cnt <= test_cnt + CNT_ONE;
          end
          err_cnt <= err_cnt_next;
          // Only the first mismatch is captured.
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec;
          end
          if (vec == 3'b111) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt_next == '0);
            state <= DONE;
          end else begin
            vec        <= vec + 3'd1;
            settle_cnt <= 4'd0;
            state      <= SETTLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_o        = vec[2];
  assign bus.b_o        = vec[1];
  assign bus.c_o        = vec[0];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.test_cnt   = test_cnt;
  assign bus.err_cnt    = err_cnt;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;

endmodule
`default_nettype wire
